// File: rtl/calc_op_sequencer.sv
// Registered front end for the 4-bit combinational calculator: accepts one op per
// handshake, captures R/ovf after a settle cycle and keeps an accumulator, sticky ovf and op counter.
module calc_op_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic [2:0]       calc_op,
    output logic [3:0]       calc_a,
    output logic [3:0]       calc_b,
    input  logic [3:0]       calc_r,
    input  logic             calc_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_r,
    output logic             out_ovf,
    output logic [3:0]       acc,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     stateQ;
    state_t     stateD;
    logic       accept;
    logic       execNow;
    logic [3:0] accNext;

    assign accept  = (stateQ == IDLE) && in_valid;
    assign execNow = (stateQ == EXEC);
    assign accNext = acc_clr ? 4'd0 : acc;

    // in_ready is gated by rst_n so it reads 0 while reset is held
    assign in_ready  = rst_n && (stateQ == IDLE);
    assign out_valid = (stateQ == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (in_valid) stateD = EXEC;
            EXEC:    stateD = HOLD;
            HOLD:    if (out_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_op <= '0;
            calc_a  <= '0;
            calc_b  <= '0;
        end else if (accept) begin
            calc_op <= in_op;
            calc_a  <= in_use_acc ? accNext : in_a;
            calc_b  <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r   <= '0;
            out_ovf <= 1'b0;
            op_cnt  <= '0;
        end else if (execNow) begin
            out_r   <= calc_r;
            out_ovf <= calc_ovf;
            op_cnt  <= op_cnt + CNT_W'(1);
        end
    end

    // acc_clr takes priority over the EXEC capture for acc and sticky_ovf only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            sticky_ovf <= 1'b0;
        end else if (acc_clr) begin
            acc        <= '0;
            sticky_ovf <= 1'b0;
        end else if (execNow) begin
            acc        <= calc_r;
            sticky_ovf <= sticky_ovf | calc_ovf;
        end
    end

endmodule
